// File: rtl/tc_fast_ram_pkg.sv
// Shared types and lane helpers for the fast-RAM arbiter.
// The RAM macro always exposes four 64-bit lanes.
package tc_fast_ram_pkg;

    typedef enum logic {
        ARB   = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam int unsigned LANE_WIDTH = 64;
    localparam int unsigned NUM_LANES  = 4;
    localparam int unsigned RAM_WIDTH  = LANE_WIDTH * NUM_LANES;

    function automatic logic [LANE_WIDTH-1:0] lane_get(
        input logic [RAM_WIDTH-1:0] data,
        input int unsigned          idx
    );
        return data[idx*LANE_WIDTH +: LANE_WIDTH];
    endfunction

    function automatic logic [RAM_WIDTH-1:0] lanes_pack(
        input logic [LANE_WIDTH-1:0] l0,
        input logic [LANE_WIDTH-1:0] l1,
        input logic [LANE_WIDTH-1:0] l2,
        input logic [LANE_WIDTH-1:0] l3
    );
        return {l3, l2, l1, l0};
    endfunction

endpackage

// File: rtl/tc_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module tc_rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [PTR_W-1:0]   winner,
    output logic               any
);

    int unsigned w_idx;

    always_comb begin
        grant  = '0;
        winner = '0;
        any    = 1'b0;
        w_idx  = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            w_idx = (32'(ptr) + k) % NUM_REQ;
            if (!any && req[w_idx]) begin
                any          = 1'b1;
                winner       = PTR_W'(w_idx);
                grant[w_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tc_fast_ram_arbiter.sv
// Round-robin arbiter sharing one fast RAM among NUM_REQ requesters,
// with registered read response and a one-cycle whole-RAM clear sequence.
module tc_fast_ram_arbiter
    import tc_fast_ram_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 256
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    input  logic                          clear_req,
    output logic                          clear_done,
    output logic                          ram_load,
    output logic                          ram_save,
    output logic                          ram_rst,
    output logic [ADDR_WIDTH-1:0]         ram_address,
    output logic [63:0]                   ram_in0,
    output logic [63:0]                   ram_in1,
    output logic [63:0]                   ram_in2,
    output logic [63:0]                   ram_in3,
    input  logic [63:0]                   ram_out0,
    input  logic [63:0]                   ram_out1,
    input  logic [63:0]                   ram_out2,
    input  logic [63:0]                   ram_out3
);

    localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t                  r_state, w_state_next;
    logic [PW-1:0]           r_rr_ptr;
    logic [ADDR_WIDTH-1:0]   r_addr_hold;
    logic [NUM_REQ-1:0]      r_rsp_valid;
    logic [DATA_WIDTH-1:0]   r_rsp_rdata;
    logic                    r_clear_done;

    logic [NUM_REQ-1:0]      w_grant;
    logic [PW-1:0]           w_winner;
    logic                    w_any;
    logic                    w_fire;
    logic                    w_sel_write;
    logic [ADDR_WIDTH-1:0]   w_sel_addr;
    logic [DATA_WIDTH-1:0]   w_sel_wdata;
    logic [RAM_WIDTH-1:0]    w_wdata_full;
    logic [RAM_WIDTH-1:0]    w_rdata_full;
    logic [DATA_WIDTH-1:0]   w_rdata_trunc;
    logic [PW-1:0]           w_ptr_next;
    int unsigned             w_sel;

    tc_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PW)
    ) u_rr (
        .req    (req_valid),
        .ptr    (r_rr_ptr),
        .grant  (w_grant),
        .winner (w_winner),
        .any    (w_any)
    );

    always_comb begin
        w_sel       = 32'(w_winner);
        w_sel_write = req_write[w_sel];
        w_sel_addr  = req_addr[w_sel*ADDR_WIDTH +: ADDR_WIDTH];
        w_sel_wdata = req_wdata[w_sel*DATA_WIDTH +: DATA_WIDTH];
    end

    // Narrow configurations zero-fill the upper lanes and drop them on read.
    assign w_wdata_full  = RAM_WIDTH'(w_sel_wdata);
    assign w_rdata_full  = lanes_pack(ram_out0, ram_out1, ram_out2, ram_out3);
    assign w_rdata_trunc = w_rdata_full[DATA_WIDTH-1:0];

    assign w_fire     = (r_state == ARB) && w_any;
    assign w_ptr_next = (w_winner == PW'(NUM_REQ - 1)) ? '0 : w_winner + PW'(1);

    always_comb begin
        w_state_next = r_state;
        req_ready    = '0;
        ram_load     = 1'b0;
        ram_save     = 1'b0;
        ram_rst      = 1'b0;
        ram_address  = '0;
        ram_in0      = '0;
        ram_in1      = '0;
        ram_in2      = '0;
        ram_in3      = '0;
        // Outputs are gated by rst so no RAM access leaks out while held in reset.
        if (rst) begin
            ram_address = r_addr_hold;
            case (r_state)
                ARB: begin
                    if (clear_req) begin
                        w_state_next = CLEAR;
                    end
                    if (w_any) begin
                        req_ready   = w_grant;
                        ram_address = w_sel_addr;
                        if (w_sel_write) begin
                            ram_save = 1'b1;
                            ram_in0  = lane_get(w_wdata_full, 0);
                            ram_in1  = lane_get(w_wdata_full, 1);
                            ram_in2  = lane_get(w_wdata_full, 2);
                            ram_in3  = lane_get(w_wdata_full, 3);
                        end else begin
                            ram_load = 1'b1;
                        end
                    end
                end
                CLEAR: begin
                    ram_rst      = 1'b1;
                    w_state_next = ARB;
                end
                default: w_state_next = ARB;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ARB;
            r_rr_ptr     <= '0;
            r_addr_hold  <= '0;
            r_rsp_valid  <= '0;
            r_rsp_rdata  <= '0;
            r_clear_done <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_clear_done <= (r_state == CLEAR);
            r_rsp_valid  <= '0;
            if (w_fire) begin
                r_rr_ptr    <= w_ptr_next;
                r_addr_hold <= w_sel_addr;
                if (!w_sel_write) begin
                    r_rsp_valid <= w_grant;
                    r_rsp_rdata <= w_rdata_trunc;
                end
            end
        end
    end

    assign rsp_valid  = r_rsp_valid;
    assign rsp_rdata  = r_rsp_rdata;
    assign clear_done = r_clear_done;

endmodule
